// File: rtl/obi_sram_pkg.sv
// obi_sram_pkg
//   Shared types and elaboration-time helpers for the pipelined OBI SRAM slave.
//   - rsp_t       : response record (read data + error) at the default 32-bit width;
//                   the top declares an equivalent record sized by its DATA_WIDTH.
//   - lsb_bits    : number of byte-offset address bits for a given data width.
//   - idx_bits    : number of word-index bits for a given memory depth.
//   - cnt_bits    : width of a counter able to hold 0..depth.
//   - base_aligned: true when a base address is aligned to the memory size.
package obi_sram_pkg;

    localparam int OBI_DW_DEFAULT = 32;

    typedef struct packed {
        logic [OBI_DW_DEFAULT-1:0] rdata;
        logic                      err;
    } rsp_t;

    function automatic int lsb_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int idx_bits(input int mem_depth);
        return (mem_depth > 1) ? $clog2(mem_depth) : 1;
    endfunction

    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit base_aligned(input logic [63:0] base, input int mem_bytes);
        return (base & (64'(mem_bytes) - 64'd1)) == 64'd0;
    endfunction

endpackage

// File: rtl/obi_rsp_fifo.sv
// obi_rsp_fifo
//   In-order, flop-based FIFO carrying OBI responses. Any DEPTH >= 1; pointers
//   wrap explicitly so non-power-of-2 depths work. Storage is not reset; the
//   consumer must qualify data_o with empty_o.
// Ports
//   clk_i    in   clock, rising edge
//   reset_i  in   asynchronous active-high reset (empties the FIFO)
//   push_i   in   write data_i (ignored when full)
//   data_i   in   entry to push
//   pop_i    in   drop head entry (ignored when empty)
//   data_o   out  head entry
//   full_o   out  count == DEPTH
//   empty_o  out  count == 0
//   count_o  out  number of stored entries
module obi_rsp_fifo
    import obi_sram_pkg::*;
#(
    parameter type T     = logic,
    parameter int  DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  T                           data_i,
    input  logic                       pop_i,
    output T                           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = cnt_bits(DEPTH);

    T                   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               do_push, do_pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i  & ~empty_o;

    always_comb begin
        wr_ptr_d = do_push ? wrap_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? wrap_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/obi_sram_slave_pipe.sv
// obi_sram_slave_pipe
//   Pipelined, byte-enabled OBI subordinate backed by a word-aligned SRAM.
//   Up to RSP_DEPTH transactions may be outstanding; responses return in order
//   through a response FIFO, at the earliest in the cycle after the accepting edge.
//   Optional feature macro: OBI_SRAM_RANGE_CHECK_EN
//     defined     : addresses outside the memory window respond with err=1,
//                   writes are suppressed and read data is 0.
//     not defined : no range compare, addresses wrap modulo the memory size,
//                   obi_err_o is always 0.
// Ports
//   clk_i         in   clock, rising edge
//   reset_i       in   asynchronous active-high reset
//   obi_req_i     in   A-channel request
//   obi_gnt_o     out  A-channel grant (response FIFO has room, not in reset)
//   obi_addr_i    in   byte address
//   obi_we_i      in   1 = write, 0 = read
//   obi_be_i      in   byte enables (writes only)
//   obi_wdata_i   in   write data
//   obi_rvalid_o  out  response valid
//   obi_rready_i  in   response ready
//   obi_rdata_o   out  read data (0 for writes, errors and when idle)
//   obi_err_o     out  response error
module obi_sram_slave_pipe
    import obi_sram_pkg::*;
#(
    parameter int                   ADDR_WIDTH = 32,
    parameter int                   DATA_WIDTH = 32,
    parameter int                   MEM_DEPTH  = 64,
    parameter int                   RSP_DEPTH  = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      obi_req_i,
    output logic                      obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]     obi_addr_i,
    input  logic                      obi_we_i,
    input  logic [DATA_WIDTH/8-1:0]   obi_be_i,
    input  logic [DATA_WIDTH-1:0]     obi_wdata_i,
    output logic                      obi_rvalid_o,
    input  logic                      obi_rready_i,
    output logic [DATA_WIDTH-1:0]     obi_rdata_o,
    output logic                      obi_err_o
);

    localparam int NBYTES    = DATA_WIDTH / 8;
    localparam int LSB       = lsb_bits(DATA_WIDTH);
    localparam int IDX_W     = idx_bits(MEM_DEPTH);
    localparam int CNT_W     = cnt_bits(RSP_DEPTH);
    localparam int MEM_BYTES = MEM_DEPTH * NBYTES;
    localparam bit BASE_OK   = base_aligned(64'(BASE_ADDR), MEM_BYTES);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES_EXT = (ADDR_WIDTH+1)'(MEM_BYTES);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } rsp_w_t;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      idx;
    logic                  in_range;
    logic                  accept;
    logic                  wr_en;
    rsp_w_t                push_rsp;
    rsp_w_t                head_rsp;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  pop;
    logic                  unused_addr_bits;

    // Offset from base; the sub-word byte bits and, without the range check,
    // the bits above the index simply do not participate in the decode.
    assign offset           = obi_addr_i - BASE_ADDR;
    assign idx              = offset[LSB +: IDX_W];
    assign unused_addr_bits = ^{offset, BASE_OK};

`ifdef OBI_SRAM_RANGE_CHECK_EN
    // Unsigned subtraction: addresses below the base wrap to huge offsets and fail too.
    assign in_range = ({1'b0, offset} < MEM_BYTES_EXT);
`else
    assign in_range = 1'b1;
`endif

    // Grant depends only on FIFO occupancy (never on rready) and is held low in reset.
    assign obi_gnt_o = ~reset_i & (fifo_count < CNT_W'(RSP_DEPTH));
    assign accept    = obi_req_i & obi_gnt_o;
    assign wr_en     = accept & obi_we_i & in_range;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (obi_be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= obi_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read data is captured from the array before this edge's write could land;
    // a read never shares an accepting edge with a write, so this is always current.
    always_comb begin
        push_rsp       = '0;
        push_rsp.err   = ~in_range;
        push_rsp.rdata = (~obi_we_i & in_range) ? mem_q[idx] : '0;
    end

    assign pop = obi_rvalid_o & obi_rready_i;

    obi_rsp_fifo #(
        .T     (rsp_w_t),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (accept & ~fifo_full),
        .data_i  (push_rsp),
        .pop_i   (pop),
        .data_o  (head_rsp),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign obi_rvalid_o = ~fifo_empty;
    assign obi_rdata_o  = fifo_empty ? '0   : head_rsp.rdata;
    assign obi_err_o    = fifo_empty ? 1'b0 : head_rsp.err;

endmodule

// File: tb/tb_obi_sram_slave_pipe.sv
module tb_obi_sram_slave_pipe;

`ifdef OBI_SRAM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    obi_sram_slave_pipe #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (64),
        .RSP_DEPTH  (2),
        .BASE_ADDR  (32'h0)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .obi_req_i    (req),
        .obi_gnt_o    (gnt),
        .obi_addr_i   (addr),
        .obi_we_i     (we),
        .obi_be_i     (be),
        .obi_wdata_i  (wdata),
        .obi_rvalid_o (rvalid),
        .obi_rready_i (rready),
        .obi_rdata_o  (rdata),
        .obi_err_o    (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0011_2233;
    endfunction

    task automatic set_a(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        req = r; we = w; addr = a; wdata = d; be = b;
    endtask

    // One isolated transaction with rready=1; starts just after a falling edge.
    task automatic single(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          input logic [31:0] exp_d, input logic exp_e);
        set_a(1'b1, w, a, d, b);
        #1 chk({tag, ".gnt"}, 64'(gnt), 64'd1);
        @(negedge clk);
        req = 1'b0;
        #1;
        chk({tag, ".rvalid"}, 64'(rvalid), 64'd1);
        chk({tag, ".rdata"},  64'(rdata),  64'(exp_d));
        chk({tag, ".err"},    64'(err),    64'(exp_e));
        @(negedge clk);
        #1 chk({tag, ".rvalid_off"}, 64'(rvalid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        rready = 1'b1;
        set_a(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset state: grant low even with a pending request, no response.
        repeat (2) @(negedge clk);
        #1;
        chk("rst.gnt",    64'(gnt),    64'd0);
        chk("rst.rvalid", 64'(rvalid), 64'd0);
        chk("rst.rdata",  64'(rdata),  64'd0);
        chk("rst.err",    64'(err),    64'd0);
        @(negedge clk);
        reset = 1'b0;
        req   = 1'b0;
        #1 chk("rst.gnt_after", 64'(gnt), 64'd1);

        // Full-word write then read.
        @(negedge clk);
        single("t1w", 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        single("t1r", 1'b0, 32'h08, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0);

        // Byte-enable patterns.
        single("t2w_b2",  1'b1, 32'h08, 32'h00AA0000, 4'b0100, 32'h0, 1'b0);
        single("t2r_b2",  1'b0, 32'h08, 32'h0,        4'h0,    32'hDEAABEEF, 1'b0);
        single("t2w_b0",  1'b1, 32'h08, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
        single("t2r_b0",  1'b0, 32'h08, 32'h0,        4'h0,    32'hDEAABEEF, 1'b0);
        single("t2w_b30", 1'b1, 32'h08, 32'h11223344, 4'b1001, 32'h0, 1'b0);
        single("t2r_lsb", 1'b0, 32'h0B, 32'h0,        4'h0,    32'h11AABE44, 1'b0);

        // Write immediately followed by read of the same word.
        set_a(1'b1, 1'b1, 32'h0C, 32'hCAFEF00D, 4'hF);
        #1 chk("t2bb.gnt_w", 64'(gnt), 64'd1);
        @(negedge clk);
        set_a(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0);
        #1;
        chk("t2bb.gnt_r", 64'(gnt),   64'd1);
        chk("t2bb.wrsp",  64'(rdata), 64'd0);
        @(negedge clk);
        req = 1'b0;
        #1;
        chk("t2bb.rvalid", 64'(rvalid), 64'd1);
        chk("t2bb.rdata",  64'(rdata),  64'hCAFEF00D);
        @(negedge clk);

        // Backpressure with two outstanding reads.
        single("t3w0", 1'b1, 32'h00, 32'hA0A0A0A0, 4'hF, 32'h0, 1'b0);
        single("t3w1", 1'b1, 32'h04, 32'hB1B1B1B1, 4'hF, 32'h0, 1'b0);
        single("t3w4", 1'b1, 32'h10, 32'hC2C2C2C2, 4'hF, 32'h0, 1'b0);
        rready = 1'b0;
        set_a(1'b1, 1'b0, 32'h00, 32'h0, 4'h0);
        #1 chk("t3.gnt1", 64'(gnt), 64'd1);
        @(negedge clk);
        addr = 32'h04;
        #1;
        chk("t3.gnt2",   64'(gnt),    64'd1);
        chk("t3.rvalid", 64'(rvalid), 64'd1);
        chk("t3.head0",  64'(rdata),  64'hA0A0A0A0);
        @(negedge clk);
        addr = 32'h10;
        #1;
        chk("t3.gnt3_full", 64'(gnt),   64'd0);
        chk("t3.head0_b",   64'(rdata), 64'hA0A0A0A0);
        @(negedge clk);
        #1;
        chk("t3.gnt3_hold", 64'(gnt),   64'd0);
        chk("t3.head0_c",   64'(rdata), 64'hA0A0A0A0);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        #1;
        chk("t3.gnt_after_pop", 64'(gnt),   64'd1);
        chk("t3.head1",         64'(rdata), 64'hB1B1B1B1);
        @(negedge clk);
        req = 1'b0;
        #1;
        chk("t3.full_again", 64'(gnt),   64'd0);
        chk("t3.head1_b",    64'(rdata), 64'hB1B1B1B1);
        rready = 1'b1;
        @(negedge clk);
        #1;
        chk("t3.rvalid2", 64'(rvalid), 64'd1);
        chk("t3.head2",   64'(rdata),  64'hC2C2C2C2);
        @(negedge clk);
        #1 chk("t3.drained", 64'(rvalid), 64'd0);

        // Eight back-to-back writes then eight back-to-back reads, rready=1.
        for (int i = 0; i < 8; i++) begin
            set_a(1'b1, 1'b1, 32'(i * 4), pat(i), 4'hF);
            #1 chk($sformatf("t4w.gnt%0d", i), 64'(gnt), 64'd1);
            if (i > 0) chk($sformatf("t4w.rvalid%0d", i), 64'(rvalid), 64'd1);
            @(negedge clk);
        end
        req = 1'b0;
        #1 chk("t4w.rvalid_last", 64'(rvalid), 64'd1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_a(1'b1, 1'b0, 32'(i * 4), 32'h0, 4'h0);
            #1 chk($sformatf("t4r.gnt%0d", i), 64'(gnt), 64'd1);
            if (i > 0) begin
                chk($sformatf("t4r.rvalid%0d", i), 64'(rvalid), 64'd1);
                chk($sformatf("t4r.rdata%0d", i - 1), 64'(rdata), 64'(pat(i - 1)));
            end
            @(negedge clk);
        end
        req = 1'b0;
        #1;
        chk("t4r.rvalid_last", 64'(rvalid), 64'd1);
        chk("t4r.rdata7",      64'(rdata),  64'(pat(7)));
        @(negedge clk);
        #1 chk("t4r.drained", 64'(rvalid), 64'd0);

        // Out-of-window address: error with the check, wrap to word 0 without.
        single("t5w",  1'b1, 32'h100, 32'h55AA55AA, 4'hF, 32'h0, RC);
        single("t5r0", 1'b0, 32'h000, 32'h0, 4'h0, RC ? pat(0) : 32'h55AA55AA, 1'b0);
        single("t5rh", 1'b0, 32'h100, 32'h0, 4'h0, RC ? 32'h0 : 32'h55AA55AA, RC);

        // Reset with two responses pending.
        rready = 1'b0;
        set_a(1'b1, 1'b0, 32'h04, 32'h0, 4'h0);
        #1 chk("t6.gnt1", 64'(gnt), 64'd1);
        @(negedge clk);
        addr = 32'h08;
        #1 chk("t6.gnt2", 64'(gnt), 64'd1);
        @(negedge clk);
        #1;
        chk("t6.full",   64'(gnt),    64'd0);
        chk("t6.rvalid", 64'(rvalid), 64'd1);
        reset = 1'b1;
        #1;
        chk("t6.rst_rvalid", 64'(rvalid), 64'd0);
        chk("t6.rst_gnt",    64'(gnt),    64'd0);
        chk("t6.rst_rdata",  64'(rdata),  64'd0);
        @(negedge clk);
        reset  = 1'b0;
        req    = 1'b0;
        rready = 1'b1;
        #1;
        chk("t6.rel_gnt",    64'(gnt),    64'd1);
        chk("t6.rel_rvalid", 64'(rvalid), 64'd0);
        @(negedge clk);
        #1 chk("t6.empty", 64'(rvalid), 64'd0);
        @(negedge clk);
        single("t6r", 1'b0, 32'h04, 32'h0, 4'h0, pat(1), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
